// File: rtl/counter_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : counter_cmd_ctrl
// Purpose : Turns debounced button levels into one-cycle enable/up/load strobes
//           for the up/down/load counter, with arbitration and saturation.
//           Auto-repeat of a held up/down key is built only when the macro
//           COUNTER_CMD_AUTOREPEAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module counter_cmd_ctrl #(
  parameter int BITS          = 8,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_req,
  input  logic            down_req,
  input  logic            load_req,
  input  logic [BITS-1:0] count_q,
  output logic            cnt_en,
  output logic            cnt_up,
  output logic            cnt_load,
  output logic            sat_hit,
  output logic            repeat_active
);

  localparam logic [BITS-1:0] COUNT_MAX = '1;

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1 || BITS < 1) begin : g_cfg_check
    $error("counter_cmd_ctrl: illegal parameter set");
  end

  logic up_q, down_q, load_q;
  logic up_rise, down_rise, load_rise;

  // Last-sample registers reset high so a key held through reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q   <= 1'b1;
      down_q <= 1'b1;
      load_q <= 1'b1;
    end else begin
      up_q   <= up_req;
      down_q <= down_req;
      load_q <= load_req;
    end
  end

  assign up_rise   = up_req   & ~up_q;
  assign down_rise = down_req & ~down_q;
  assign load_rise = load_req & ~load_q;

  logic step_req, step_dir, load_go, rep_d;

`ifdef COUNTER_CMD_AUTOREPEAT_EN
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW      = $clog2(TMR_MAX);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          dir, dir_n;
  logic [TW-1:0] timer, timer_n;
  logic          key_lost;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      timer <= timer_n;
    end
  end

  assign key_lost = dir ? (~up_req | down_req) : (~down_req | up_req);

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    timer_n  = timer;
    step_req = 1'b0;
    step_dir = dir;
    load_go  = 1'b0;
    case (state)
      IDLE: begin
        if (load_rise) begin
          load_go = 1'b1;
        end else if (up_rise ^ down_rise) begin
          step_req = 1'b1;
          step_dir = up_rise;
          dir_n    = up_rise;
          state_n  = HOLD;
          timer_n  = '0;
        end
      end
      HOLD: begin
        if (load_rise || key_lost) begin
          load_go = load_rise;
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == HOLD_LAST) begin
          step_req = 1'b1;
          state_n  = REPEAT;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      REPEAT: begin
        if (load_rise || key_lost) begin
          load_go = load_rise;
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == REPEAT_LAST) begin
          step_req = 1'b1;
          timer_n  = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
    rep_d = (state_n == REPEAT);
  end
`else
  always_comb begin
    load_go  = load_rise;
    step_req = ~load_rise & (up_rise ^ down_rise);
    step_dir = up_rise;
    rep_d    = 1'b0;
  end
`endif

  logic at_limit, suppress;
  logic en_d, up_d, load_d, sat_d;

  always_comb begin
    at_limit = step_dir ? (count_q == COUNT_MAX) : (count_q == '0);
    suppress = (WRAP == 0) && step_req && at_limit;
    en_d     = load_go | (step_req & ~suppress);
    up_d     = step_req & ~suppress & step_dir;
    load_d   = load_go;
    sat_d    = step_req & suppress;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_en        <= 1'b0;
      cnt_up        <= 1'b0;
      cnt_load      <= 1'b0;
      sat_hit       <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      cnt_en        <= en_d;
      cnt_up        <= up_d;
      cnt_load      <= load_d;
      sat_hit       <= sat_d;
      repeat_active <= rep_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_ctrl.sv
`default_nettype none
// Scoreboard bench for counter_cmd_ctrl: stimulus pushes expected strobes, a
// negedge monitor pops and compares them; a WRAP=1 twin checks the wrap path.
module tb_counter_cmd_ctrl;
  localparam int BITS = 8, HOLD_CYCLES = 4, REPEAT_CYCLES = 2;
`ifdef COUNTER_CMD_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic up_req = 1'b0, down_req = 1'b0, load_req = 1'b0;
  logic [BITS-1:0] count_q = 8'h40;
  logic cnt_en, cnt_up, cnt_load, sat_hit, repeat_active;
  logic w_en, w_up, w_load, w_sat, w_rep;
  int cyc = 0, vectors = 0, miscompares = 0;

  typedef struct {int at; logic en; logic up; logic load; logic sat;} exp_t;
  exp_t sbq[$];

  counter_cmd_ctrl #(.BITS(BITS), .WRAP(0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) dut (
    .clk(clk), .rst(rst), .up_req(up_req), .down_req(down_req), .load_req(load_req),
    .count_q(count_q), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .sat_hit(sat_hit), .repeat_active(repeat_active));

  counter_cmd_ctrl #(.BITS(BITS), .WRAP(1), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) dut_w (
    .clk(clk), .rst(rst), .up_req(up_req), .down_req(down_req), .load_req(load_req),
    .count_q(count_q), .cnt_en(w_en), .cnt_up(w_up), .cnt_load(w_load),
    .sat_hit(w_sat), .repeat_active(w_rep));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].at < cyc) begin
      e = sbq.pop_front();
      vectors++; miscompares++;
      $display("FAIL missing_strobe: nothing seen, required strobe at cycle %0d (now %0d)", e.at, cyc);
    end
    if (!rst && (cnt_en || cnt_load || sat_hit)) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got en/up/load/sat=%b%b%b%b at cycle %0d, required none",
                 cnt_en, cnt_up, cnt_load, sat_hit, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.at != cyc || e.en !== cnt_en || e.up !== cnt_up || e.load !== cnt_load || e.sat !== sat_hit) begin
          miscompares++;
          $display("FAIL strobe: got cycle %0d en/up/load/sat=%b%b%b%b, required cycle %0d %b%b%b%b",
                   cyc, cnt_en, cnt_up, cnt_load, sat_hit, e.at, e.en, e.up, e.load, e.sat);
        end
      end
      vectors++;
      if (sat_hit) begin
        if (!(w_en === 1'b1 && w_sat === 1'b0 && w_up === (count_q == 8'hFF))) begin
          miscompares++;
          $display("FAIL wrap_step: got en/up/sat=%b%b%b, required 1%b0", w_en, w_up, w_sat, count_q == 8'hFF);
        end
      end else if ({w_en, w_up, w_load, w_sat} !== {cnt_en, cnt_up, cnt_load, 1'b0}) begin
        miscompares++;
        $display("FAIL wrap_twin: got en/up/load/sat=%b%b%b%b, required %b%b%b0",
                 w_en, w_up, w_load, w_sat, cnt_en, cnt_up, cnt_load);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input int at, input logic en, input logic up, input logic load, input logic sat);
    sbq.push_back('{at, en, up, load, sat});
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    // 1: key held through reset gives no strobe; a fresh press gives one
    up_req = 1'b1;
    tick(3);
    check("reset_outputs", {cnt_en, cnt_up, cnt_load, sat_hit, repeat_active}, 5'b0);
    rst = 1'b0;
    tick(5);
    up_req = 1'b0;
    tick(1);
    up_req = 1'b1; c = cyc;
    expect_strobe(c + 1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);
    up_req = 1'b0;
    tick(4);

    // 2: load beats a simultaneous up edge
    count_q = 8'h10;
    up_req = 1'b1; load_req = 1'b1; c = cyc;
    expect_strobe(c + 1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(2);
    up_req = 1'b0; load_req = 1'b0;
    tick(3);

    // 3: simultaneous up and down edges cancel
    up_req = 1'b1; down_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("dual_edge_no_strobe", {4'b0, cnt_en}, 5'b0);
    end
    up_req = 1'b0; down_req = 1'b0;
    tick(3);

    // 4: saturation at both limits
    count_q = 8'hFF;
    up_req = 1'b1; c = cyc;
    expect_strobe(c + 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    up_req = 1'b0;
    tick(3);
    count_q = 8'h00;
    down_req = 1'b1; c = cyc;
    expect_strobe(c + 1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    down_req = 1'b0;
    tick(3);

    // 5: held down key, auto-repeat timing when built
    count_q = 8'h40;
    down_req = 1'b1; c = cyc;
    expect_strobe(c + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (AUTO) begin
      expect_strobe(c + 5,  1'b1, 1'b0, 1'b0, 1'b0);
      expect_strobe(c + 7,  1'b1, 1'b0, 1'b0, 1'b0);
      expect_strobe(c + 9,  1'b1, 1'b0, 1'b0, 1'b0);
      expect_strobe(c + 11, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(4);
    check("repeat_active_hold", {4'b0, repeat_active}, 5'b0);
    tick(2);
    check("repeat_active_repeat", {4'b0, repeat_active}, {4'b0, AUTO});
    tick(6);
    down_req = 1'b0;
    tick(1);
    check("repeat_active_released", {4'b0, repeat_active}, 5'b0);
    tick(4);

    // 6: asynchronous reset during repeat, key still held afterwards
    down_req = 1'b1; c = cyc;
    expect_strobe(c + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (AUTO) expect_strobe(c + 5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(7);
    #1 rst = 1'b1;
    #1 check("async_reset_outputs", {cnt_en, cnt_up, cnt_load, sat_hit, repeat_active}, 5'b0);
    tick(2);
    rst = 1'b0;
    tick(8);
    check("after_reset_idle", {cnt_en, cnt_up, cnt_load, sat_hit, repeat_active}, 5'b0);
    down_req = 1'b0;
    tick(3);

    while (sbq.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL missing_strobe: nothing seen, required strobe at cycle %0d", sbq[0].at);
      void'(sbq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
